// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: holds one core request across bus wait states,
// splits misaligned accesses into byte beats (or faults them) and extends load data.
module lsu_bus_ctrl #(
    parameter int XLEN             = 32,
    parameter int TIMEOUT          = 255,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            stall,
    output logic [XLEN-1:0] DAD,
    output logic [XLEN-1:0] DDT_out,
    output logic            DDT_oe,
    input  logic [XLEN-1:0] DDT_in,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    input  logic            ACKD_n
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

    state_t          state;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, acc_q;
    logic            split_q;
    logic [2:0]      beat_q, last_q;
    logic [CW-1:0]   wcnt_q;

    logic [3:0]      req_bytes;
    logic            req_illegal, req_aligned;
    logic [XLEN-1:0] acc_next, wsh;

    function automatic logic [1:0] size_code(input logic [1:0] w);
        case (w)
            2'd0:    return 2'b11;
            2'd1:    return 2'b01;
            2'd2:    return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] byte_mask(input logic [1:0] w);
        case (w)
            2'd0:    return XLEN'(8'hFF);
            2'd1:    return XLEN'(16'hFFFF);
            2'd2:    return XLEN'(32'hFFFF_FFFF);
            default: return '1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  return XLEN'($signed(d[7:0]));
            3'b001:  return XLEN'($signed(d[15:0]));
            3'b010:  return XLEN'($signed(d[31:0]));
            3'b100:  return XLEN'(d[7:0]);
            3'b101:  return XLEN'(d[15:0]);
            3'b110:  return XLEN'(d[31:0]);
            default: return d;
        endcase
    endfunction

    // 110 stays legal only as LWU on 64-bit loads; stores never take the unsigned codes
    always_comb begin
        req_bytes   = 4'd1 << req_funct3[1:0];
        req_illegal = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) ||
                      (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
        req_aligned = (req_addr[2:0] & 3'(req_bytes - 4'd1)) == 3'd0;
    end

    // split loads gather one byte per beat at its little-endian slot
    assign acc_next = split_q ? (acc_q | (XLEN'(DDT_in[7:0]) << {beat_q, 3'b000})) : DDT_in;
    assign wsh      = wdata_q >> {beat_q, 3'b000};

    assign req_ready = (state == IDLE);
    assign stall     = (state == BUS) || (state == GAP) || (state == IDLE && req_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            acc_q     <= '0;
            split_q   <= 1'b0;
            beat_q    <= '0;
            last_q    <= '0;
            wcnt_q    <= '0;
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            DDT_oe    <= 1'b0;
            DAD       <= '0;
            DDT_out   <= '0;
            SIZE      <= 2'b11;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    acc_q   <= '0;
                    beat_q  <= '0;
                    wcnt_q  <= '0;
                    split_q <= !req_aligned;
                    last_q  <= req_aligned ? 3'd0 : 3'(req_bytes - 4'd1);
                    if (req_illegal || (!req_aligned && !SPLIT_MISALIGNED)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state  <= BUS;
                        MREQ   <= 1'b1;
                        WRITE  <= req_write;
                        DDT_oe <= req_write;
                        DAD    <= req_addr;
                        if (req_aligned) begin
                            SIZE    <= size_code(req_funct3[1:0]);
                            DDT_out <= req_write ? (req_wdata & byte_mask(req_funct3[1:0])) : '0;
                        end else begin
                            SIZE    <= 2'b11;
                            DDT_out <= req_write ? XLEN'(req_wdata[7:0]) : '0;
                        end
                    end
                end
                BUS: begin
                    if (!ACKD_n) begin
                        wcnt_q <= '0;
                        MREQ   <= 1'b0;
                        WRITE  <= 1'b0;
                        DDT_oe <= 1'b0;
                        if (!wr_q) acc_q <= acc_next;
                        if (beat_q == last_q) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= wr_q ? '0 : load_extend(f3_q, acc_next);
                        end else begin
                            state  <= GAP;
                            beat_q <= beat_q + 3'd1;
                        end
                    end else if (TIMEOUT != 0 && int'(wcnt_q) + 1 >= TIMEOUT) begin
                        state     <= RESP;
                        MREQ      <= 1'b0;
                        WRITE     <= 1'b0;
                        DDT_oe    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (wcnt_q != '1) begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                GAP: begin
                    state   <= BUS;
                    wcnt_q  <= '0;
                    MREQ    <= 1'b1;
                    WRITE   <= wr_q;
                    DDT_oe  <= wr_q;
                    DAD     <= addr_q + XLEN'(beat_q);
                    DDT_out <= wr_q ? XLEN'(wsh[7:0]) : '0;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized bench for lsu_bus_ctrl: a 32-bit split/timeout instance and a 64-bit
// no-split instance share one bus slave and one byte-array reference model.
module tb_lsu_bus_ctrl;
    localparam int TO_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        ACKD_n = 1'b1;
    logic [63:0] DDT_in = '0;

    logic        a_ready, a_valid, a_err, a_stall, a_oe, a_mreq, a_write;
    logic [1:0]  a_size;
    logic [31:0] a_rdata, a_dad, a_dout;
    logic        b_ready, b_valid, b_err, b_stall, b_oe, b_mreq, b_write;
    logic [1:0]  b_size;
    logic [63:0] b_rdata, b_dad, b_dout;

    lsu_bus_ctrl #(.XLEN(32), .TIMEOUT(TO_A), .SPLIT_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(a_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err), .stall(a_stall),
        .DAD(a_dad), .DDT_out(a_dout), .DDT_oe(a_oe), .DDT_in(DDT_in[31:0]),
        .MREQ(a_mreq), .WRITE(a_write), .SIZE(a_size), .ACKD_n(ACKD_n)
    );

    lsu_bus_ctrl #(.XLEN(64), .TIMEOUT(0), .SPLIT_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(b_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err), .stall(b_stall),
        .DAD(b_dad), .DDT_out(b_dout), .DDT_oe(b_oe), .DDT_in(DDT_in),
        .MREQ(b_mreq), .WRITE(b_write), .SIZE(b_size), .ACKD_n(ACKD_n)
    );

    logic        o_ready, o_valid, o_err, o_stall, o_oe, o_mreq, o_write;
    logic [1:0]  o_size;
    logic [63:0] o_rdata, o_dad, o_dout;
    always_comb begin
        if (sel) begin
            o_ready = b_ready; o_valid = b_valid; o_err = b_err; o_stall = b_stall;
            o_oe = b_oe; o_mreq = b_mreq; o_write = b_write; o_size = b_size;
            o_rdata = b_rdata; o_dad = b_dad; o_dout = b_dout;
        end else begin
            o_ready = a_ready; o_valid = a_valid; o_err = a_err; o_stall = a_stall;
            o_oe = a_oe; o_mreq = a_mreq; o_write = a_write; o_size = a_size;
            o_rdata = {32'h0, a_rdata}; o_dad = {32'h0, a_dad}; o_dout = {32'h0, a_dout};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ix(input logic [63:0] a, input int k);
        return int'((a + 64'(k)) & 64'h3FF);
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        case (s)
            2'b11:   return 1;
            2'b01:   return 2;
            2'b00:   return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [1:0] size_of(input int nb);
        case (nb)
            1:       return 2'b11;
            2:       return 2'b01;
            4:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    // bus-side memory (slave) and the model's own view of memory
    logic [7:0] bus_mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    typedef struct {
        logic [63:0] dad;
        logic [63:0] dout;
        logic [1:0]  size;
        logic        wr;
    } beat_t;
    beat_t beat_log[$];

    int bus_wait = 0;
    int sw_cnt   = 0;

    // slave: acks after bus_wait wait cycles, drives garbage on DDT_in otherwise
    always @(negedge clk) begin
        ACKD_n = 1'b1;
        DDT_in = {$urandom, $urandom};
        if (o_mreq) begin
            if (sw_cnt >= bus_wait) begin
                ACKD_n = 1'b0;
                sw_cnt = 0;
                beat_log.push_back('{o_dad, o_dout, o_size, o_write});
                if (o_write) begin
                    for (int k = 0; k < size_bytes(o_size); k++) bus_mem[ix(o_dad, k)] = o_dout[8*k +: 8];
                end else begin
                    DDT_in = '0;
                    for (int k = 0; k < size_bytes(o_size); k++) DDT_in[8*k +: 8] = bus_mem[ix(o_dad, k)];
                end
            end else begin
                sw_cnt++;
            end
        end else begin
            sw_cnt = 0;
        end
    end

    task automatic preset(input logic [63:0] addr, input int nb, input logic [63:0] v);
        for (int k = 0; k < nb; k++) begin
            bus_mem[ix(addr, k)] = v[8*k +: 8];
            ref_mem[ix(addr, k)] = v[8*k +: 8];
        end
    endtask

    logic [63:0] last_rd;
    logic        last_err;

    task automatic run_txn(input logic d, input logic wr, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata, input int w);
        int xlen, nb, beats, exp_beats, exp_lat, exp_mreq, lat, mreq_cyc;
        bit illegal, aligned, err, tmo, stall_ok;
        logic [63:0] exp_rd, v, nb_mask;
        xlen     = d ? 64 : 32;
        nb       = 1 << f3[1:0];
        nb_mask  = (nb == 8) ? '1 : ((64'h1 << (8*nb)) - 64'h1);
        illegal  = (f3 == 3'b111) || (wr && f3[2]) || (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110));
        aligned  = (addr % nb) == 0;
        err      = illegal || (!aligned && d);
        beats    = aligned ? 1 : nb;
        tmo      = !err && !d && w >= TO_A;
        exp_rd   = '0;
        if (err) begin
            exp_lat = 1; exp_mreq = 0; exp_beats = 0;
        end else if (tmo) begin
            exp_lat = 1 + TO_A; exp_mreq = TO_A; exp_beats = 0;
        end else begin
            exp_lat = beats * (w + 1) + beats; exp_mreq = beats * (w + 1); exp_beats = beats;
            if (wr) begin
                for (int k = 0; k < nb; k++) ref_mem[ix(addr, k)] = wdata[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++) v |= 64'(ref_mem[ix(addr, k)]) << (8*k);
                if (!f3[2] && nb < 8 && v[8*nb-1]) v |= ~64'h0 << (8*nb);
                if (xlen == 32) v &= 64'hFFFF_FFFF;
                exp_rd = v;
            end
        end

        @(negedge clk);
        sel = d;
        bus_wait = w;
        beat_log.delete();
        chk("ready_idle", 64'(o_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1 chk("stall_accept", 64'(o_stall), 64'd1);

        lat = 0; mreq_cyc = 0; stall_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            lat++;
            if (o_valid || lat > 300) break;
            if (!o_stall || o_ready) stall_ok = 1'b0;
            if (o_mreq) mreq_cyc++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_err", 64'(o_err), 64'(err || tmo));
        chk("rsp_rdata", o_rdata, exp_rd);
        chk("stall_resp", 64'(o_stall), 64'd0);
        chk("stall_hold", 64'(stall_ok), 64'd1);
        chk("mreq_cycles", 64'(mreq_cyc), 64'(exp_mreq));
        chk("beat_count", 64'(beat_log.size()), 64'(exp_beats));
        foreach (beat_log[i]) begin
            if (i < exp_beats) begin
                chk("beat_dad", beat_log[i].dad, aligned ? addr : addr + 64'(i));
                chk("beat_size", 64'(beat_log[i].size), 64'(aligned ? size_of(nb) : 2'b11));
                chk("beat_write", 64'(beat_log[i].wr), 64'(wr));
                if (wr) chk("beat_ddt", beat_log[i].dout, aligned ? (wdata & nb_mask) : 64'(wdata[8*i +: 8]));
            end
        end
        last_rd  = o_rdata;
        last_err = o_err;
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [2:0] f3;
        logic [63:0] addr;
        logic d;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        #1 rst = 1'b0;
        #1;
        chk("rst_mreq", 64'(o_mreq), 64'd0);
        chk("rst_write", 64'(o_write), 64'd0);
        chk("rst_oe", 64'(o_oe), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_dad", o_dad, 64'd0);
        chk("rst_ddt", o_dout, 64'd0);
        chk("rst_size", 64'(o_size), 64'd3);
        chk("rst_size_b", 64'(b_size), 64'd3);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_stall", 64'(o_stall), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // directed scenarios
        preset(64'h100, 4, 64'hDEADBEEF);
        run_txn(1'b0, 1'b0, 3'b010, 64'h100, 64'h0, 0);
        chk("tp1_lw", last_rd, 64'hDEADBEEF);
        preset(64'h103, 1, 64'h80);
        run_txn(1'b0, 1'b0, 3'b000, 64'h103, 64'h0, 0);
        chk("tp2_lb", last_rd, 64'hFFFF_FF80);
        run_txn(1'b0, 1'b0, 3'b100, 64'h103, 64'h0, 1);
        chk("tp2_lbu", last_rd, 64'h80);
        preset(64'h104, 2, 64'h8001);
        run_txn(1'b0, 1'b0, 3'b001, 64'h104, 64'h0, 0);
        chk("tp2_lh", last_rd, 64'hFFFF_8001);
        run_txn(1'b0, 1'b1, 3'b010, 64'h201, 64'h11223344, 0);
        run_txn(1'b0, 1'b0, 3'b010, 64'h201, 64'h0, 2);
        chk("tp3_readback", last_rd, 64'h11223344);
        run_txn(1'b1, 1'b0, 3'b001, 64'h005, 64'h0, 0);
        chk("tp4_err", 64'(last_err), 64'd1);
        run_txn(1'b0, 1'b0, 3'b010, 64'h100, 64'h0, 1000);
        chk("tp5_timeout", 64'(last_err), 64'd1);
        run_txn(1'b0, 1'b0, 3'b010, 64'h100, 64'h0, TO_A - 1);
        chk("tp5_ack_wins", 64'(last_err), 64'd0);
        run_txn(1'b1, 1'b0, 3'b010, 64'h100, 64'h0, 10);

        // reset in the middle of a split store
        @(negedge clk);
        sel = 1'b0; bus_wait = 2;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 64'h381; req_wdata = 64'hCAFEF00D;
        repeat (2) @(negedge clk);
        chk("tp6_pre_mreq", 64'(o_mreq), 64'd1);
        #2 rst = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("tp6_mreq", 64'(o_mreq), 64'd0);
        chk("tp6_write", 64'(o_write), 64'd0);
        chk("tp6_oe", 64'(o_oe), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        chk("tp6_no_rsp", 64'(seen), 64'd0);
        run_txn(1'b0, 1'b0, 3'b010, 64'h000, 64'h0, 0);
        preset(64'h8, 8, 64'h0123456789ABCDEF);
        run_txn(1'b1, 1'b0, 3'b011, 64'h8, 64'h0, 0);
        chk("tp6_ld", last_rd, 64'h0123456789ABCDEF);

        // randomized traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            d    = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 64'($urandom_range(0, 16'h2F0));
            if ($urandom_range(0, 1) == 0) addr &= ~64'(7);
            run_txn(d, 1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom},
                    d ? $urandom_range(0, 6) : $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
